// File: rtl/display_scan_pkg.sv
// Shared constants, types and the segment decode for the display scanner.
package display_scan_pkg;

    localparam int NDIG = 8;

    typedef logic [3:0] code_t;
    typedef logic [6:0] seg_t;

    localparam code_t CODE_L     = 4'hA;
    localparam code_t CODE_C     = 4'hB;
    localparam code_t CODE_BLANK = 4'hC;
    localparam code_t CODE_P     = 4'hD;
    localparam code_t CODE_N     = 4'hE;
    localparam code_t CODE_A     = 4'hF;

    localparam seg_t SEG_ZERO = 7'b1111110;

    // Team glyph table, segments ordered {a,b,c,d,e,f,g}, active-high.
    function automatic seg_t seg_decode(input code_t c);
        seg_t s;
        case (c)
            4'h0:       s = 7'b1111110;
            4'h1:       s = 7'b0110000;
            4'h2:       s = 7'b1101101;
            4'h3:       s = 7'b1111001;
            4'h4:       s = 7'b0110011;
            4'h5:       s = 7'b1011011;
            4'h6:       s = 7'b1011111;
            4'h7:       s = 7'b1110000;
            4'h8:       s = 7'b1111111;
            4'h9:       s = 7'b1111011;
            CODE_L:     s = 7'b0001110;
            CODE_C:     s = 7'b1001110;
            CODE_BLANK: s = 7'b0000000;
            CODE_P:     s = 7'b1100111;
            CODE_N:     s = 7'b1110110;
            default:    s = 7'b1110111; // CODE_A
        endcase
        return s;
    endfunction

endpackage

// File: rtl/display_scan_if.sv
// Load/data bus and display outputs of the scanner.
interface display_scan_if;
    import display_scan_pkg::*;

    logic        load;
    logic [31:0] data;
    logic [7:0]  blink_mask;
    logic        lz_en;
    seg_t        seg;
    logic [7:0]  an;
    logic        frame;

    modport master (
        output load, data, blink_mask, lz_en,
        input  seg, an, frame
    );

    modport slave (
        input  load, data, blink_mask, lz_en,
        output seg, an, frame
    );
endinterface

// File: rtl/display_scan_display.sv
// Registered segment decoder; its output lines up with the registered an.
module display_scan_display
    import display_scan_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  code_t num,
    output seg_t  seg
);

    // Decode the selected code one cycle after selection.
    always_ff @(posedge clk) begin
        if (reset) seg <= SEG_ZERO;
        else       seg <= seg_decode(num);
    end

endmodule

// File: rtl/display_scan.sv
// Eight-digit multiplexed 7-segment scanner with blink and leading-zero blanking.
module display_scan
    import display_scan_pkg::*;
#(
    parameter int DIV          = 50000,
    parameter int BLINK_FRAMES = 32
) (
    input logic          clk,
    input logic          reset,
    display_scan_if.slave bus
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [CW-1:0]          cnt;
    logic [2:0]             idx;
    logic [FW-1:0]          fcnt;
    logic                   phase;
    logic [NDIG-1:0][3:0]   digits;
    logic [NDIG-1:0]        mask;
    logic [NDIG-1:0]        an;
    logic                   frame;
    logic                   tick;
    logic                   last;
    logic                   lead_zero;
    code_t                  num;
    seg_t                   seg;

    assign tick = (cnt == CW'(DIV - 1));
    assign last = tick && (idx == 3'd7);

    // Per-digit dwell counter; wraps on tick.
    always_ff @(posedge clk) begin
        if (reset)     cnt <= '0;
        else if (tick) cnt <= '0;
        else           cnt <= cnt + 1'b1;
    end

    // Digit index advances on tick, 3-bit wrap gives 7 -> 0.
    always_ff @(posedge clk) begin
        if (reset)     idx <= '0;
        else if (tick) idx <= idx + 3'd1;
    end

    // Frame counter and blink phase; phase starts visible and flips every BLINK_FRAMES scans.
    always_ff @(posedge clk) begin
        if (reset) begin
            fcnt  <= '0;
            phase <= 1'b1;
        end else if (last) begin
            if (fcnt == FW'(BLINK_FRAMES - 1)) begin
                fcnt  <= '0;
                phase <= ~phase;
            end else begin
                fcnt  <= fcnt + 1'b1;
            end
        end
    end

    // End-of-scan pulse.
    always_ff @(posedge clk) begin
        if (reset) frame <= 1'b0;
        else       frame <= last;
    end

    // Digit and blink-mask registers; load is independent of the scan position.
    always_ff @(posedge clk) begin
        if (reset) begin
            digits <= '0;
            mask   <= '0;
        end else if (bus.load) begin
            digits <= bus.data;
            mask   <= bus.blink_mask;
        end
    end

    // Anode enable registered from the same idx that feeds the decoder.
    always_ff @(posedge clk) begin
        if (reset) an <= 8'hFF;
        else       an <= ~(8'd1 << idx);
    end

    // True when the current digit and every more-significant digit are zero.
    always_comb begin
        lead_zero = 1'b1;
        for (int i = 0; i < NDIG; i++) begin
            if (i >= int'(idx) && digits[i] != 4'h0) lead_zero = 1'b0;
        end
    end

    // Code select: blink-off blanking wins, then leading-zero blanking, then the digit.
    always_comb begin
        num = digits[idx];
        if (!phase && mask[idx])                    num = CODE_BLANK;
        else if (bus.lz_en && idx != 3'd0 && lead_zero) num = CODE_BLANK;
    end

    display_scan_display display (
        .clk   (clk),
        .reset (reset),
        .num   (num),
        .seg   (seg)
    );

    assign bus.seg   = seg;
    assign bus.an    = an;
    assign bus.frame = frame;

endmodule

// File: tb/tb_display_scan.sv
// Directed bench for display_scan: arithmetic reference model plus literal checks.
module tb_display_scan;

    localparam int BF = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   passed = 0;
    int   total  = 0;

    display_scan_if bus0();
    display_scan_if bus1();

    assign bus1.load       = bus0.load;
    assign bus1.data       = bus0.data;
    assign bus1.blink_mask = bus0.blink_mask;
    assign bus1.lz_en      = bus0.lz_en;

    display_scan #(.DIV(4), .BLINK_FRAMES(BF)) dut0 (.clk(clk), .reset(rst), .bus(bus0));
    display_scan #(.DIV(1), .BLINK_FRAMES(BF)) dut1 (.clk(clk), .reset(rst), .bus(bus1));

    always #5 clk = ~clk;

    logic [7:0] an_a  [2];
    logic [6:0] seg_a [2];
    logic       fr_a  [2];
    assign an_a[0]  = bus0.an;
    assign an_a[1]  = bus1.an;
    assign seg_a[0] = bus0.seg;
    assign seg_a[1] = bus1.seg;
    assign fr_a[0]  = bus0.frame;
    assign fr_a[1]  = bus1.frame;

    function automatic logic [6:0] glyph(input logic [3:0] c);
        case (c)
            4'h0: return 7'b1111110;  4'h1: return 7'b0110000;
            4'h2: return 7'b1101101;  4'h3: return 7'b1111001;
            4'h4: return 7'b0110011;  4'h5: return 7'b1011011;
            4'h6: return 7'b1011111;  4'h7: return 7'b1110000;
            4'h8: return 7'b1111111;  4'h9: return 7'b1111011;
            4'hA: return 7'b0001110;  4'hB: return 7'b1001110;
            4'hC: return 7'b0000000;  4'hD: return 7'b1100111;
            4'hE: return 7'b1110110;  default: return 7'b1110111;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s actual=%h required=%h", name, act, exp);
        else passed++;
    endtask

    // Model: everything follows from the number of clock edges since reset.
    int         mn    [2];
    logic [31:0] mdig [2];
    logic [7:0] mmask [2];
    logic [7:0] ean   [2];
    logic [6:0] eseg  [2];
    logic       efr   [2];
    bit         mval = 0;

    initial begin
        int d, ix, fr;
        logic on, allz;
        logic [3:0] c;
        forever begin
            @(posedge clk);
            for (int k = 0; k < 2; k++) begin
                d = (k == 0) ? 4 : 1;
                if (rst) begin
                    mn[k] = 0; mdig[k] = '0; mmask[k] = '0;
                    ean[k] = 8'hFF; eseg[k] = 7'b1111110; efr[k] = 1'b0;
                end else begin
                    ix   = (mn[k] / d) % 8;
                    fr   = mn[k] / (d * 8);
                    on   = ((fr / BF) % 2) == 0;
                    c    = mdig[k][4*ix +: 4];
                    allz = (mdig[k] >> (4 * ix)) == 32'h0;
                    if (!on && mmask[k][ix])               c = 4'hC;
                    else if (bus0.lz_en && ix > 0 && allz) c = 4'hC;
                    ean[k]  = ~(8'd1 << ix);
                    eseg[k] = glyph(c);
                    efr[k]  = ((mn[k] + 1) % (8 * d)) == 0;
                    if (bus0.load) begin
                        mdig[k]  = bus0.data;
                        mmask[k] = bus0.blink_mask;
                    end
                    mn[k]++;
                end
            end
            mval = 1;
        end
    end

    // Every-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (mval) begin
                for (int k = 0; k < 2; k++) begin
                    check($sformatf("dut%0d an", k),    an_a[k],  ean[k]);
                    check($sformatf("dut%0d seg", k),   seg_a[k], eseg[k]);
                    check($sformatf("dut%0d frame", k), fr_a[k],  efr[k]);
                end
            end
        end
    end

    task automatic do_load(input logic [31:0] d, input logic [7:0] m, input logic lz);
        bus0.data = d; bus0.blink_mask = m; bus0.lz_en = lz; bus0.load = 1'b1;
        @(negedge clk);
        bus0.load = 1'b0;
    endtask

    task automatic wait_an(input int k, input logic [7:0] t, input string nm);
        int i = 0;
        while (an_a[k] !== t && i < 40) begin
            @(negedge clk);
            i++;
        end
        check({nm, " reached"}, an_a[k], t);
    endtask

    task automatic wait_model(input int idx, input int c);
        int i = 0;
        while (!((mn[0] % 4) == c && ((mn[0] / 4) % 8) == idx) && i < 64) begin
            @(negedge clk);
            i++;
        end
        check("model position reached", (i < 64), 1);
    endtask

    initial begin
        int on_cnt, off_cnt, frames;
        logic [6:0] exp39 [8];
        logic [7:0] ea;
        exp39[0] = 7'b1111111; exp39[1] = 7'b1111011; exp39[2] = 7'b0001110;
        exp39[3] = 7'b1001110; exp39[4] = 7'b0000000; exp39[5] = 7'b1100111;
        exp39[6] = 7'b1110110; exp39[7] = 7'b1110111;

        bus0.load = 1'b0; bus0.data = '0; bus0.blink_mask = '0; bus0.lz_en = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("reset an", an_a[0], 8'hFF);
        check("reset seg", seg_a[0], 7'b1111110);
        check("reset frame", fr_a[0], 1'b0);
        rst = 1'b0;

        // Plain count-up display, no suppression.
        do_load(32'h76543210, 8'h00, 1'b0);
        @(negedge clk);
        wait_an(0, 8'hF7, "digit3");
        check("digit3 seg", seg_a[0], 7'b1111001);
        frames = 0;
        repeat (64) begin
            @(negedge clk);
            if (fr_a[0] === 1'b1) frames++;
        end
        check("frames in 64 cycles", frames, 2);

        // Leading-zero suppression.
        do_load(32'h00000050, 8'h00, 1'b1);
        @(negedge clk);
        wait_an(0, 8'h7F, "lz digit7");
        check("lz digit7 blank", seg_a[0], 7'b0000000);
        wait_an(0, 8'hFE, "lz digit0");
        check("lz digit0 zero", seg_a[0], 7'b1111110);
        wait_an(0, 8'hFD, "lz digit1");
        check("lz digit1 five", seg_a[0], 7'b1011011);

        // Blink on digit 0: equal on/off time over a whole blink period pair.
        do_load(32'h00000008, 8'h01, 1'b0);
        @(negedge clk);
        on_cnt = 0; off_cnt = 0;
        repeat (256) begin
            if (an_a[0] === 8'hFE) begin
                if (seg_a[0] === 7'b1111111) on_cnt++;
                if (seg_a[0] === 7'b0000000) off_cnt++;
            end
            @(negedge clk);
        end
        check("blink on samples", on_cnt, 16);
        check("blink off samples", off_cnt, 16);

        // Load coinciding with the 2->3 tick.
        wait_model(2, 3);
        do_load(32'h0000D000, 8'h00, 1'b0);
        @(negedge clk);
        check("load+tick an", an_a[0], 8'hF7);
        check("load+tick seg", seg_a[0], 7'b1100111);

        // Reset mid-digit 5.
        wait_model(5, 1);
        rst = 1'b1;
        @(negedge clk);
        check("midreset an", an_a[0], 8'hFF);
        check("midreset seg", seg_a[0], 7'b1111110);
        rst = 1'b0;
        @(negedge clk);
        check("post-reset an", an_a[0], 8'hFE);
        check("post-reset seg", seg_a[0], 7'b1111110);

        // DIV=1: one digit per cycle, letters decoded.
        do_load(32'hFEDCBA98, 8'h00, 1'b0);
        @(negedge clk);
        wait_an(1, 8'hFE, "div1 start");
        for (int j = 0; j < 8; j++) begin
            ea = ~(8'd1 << j);
            check($sformatf("div1 an%0d", j), an_a[1], ea);
            check($sformatf("div1 seg%0d", j), seg_a[1], exp39[j]);
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/display_scan.md
DISPLAY_SCAN -- requirements
Module: display_scan

Interface
REQ-001 Parameter DIV, default 50000, clock cycles each digit is enabled; legal range 1 or more.
REQ-002 Parameter BLINK_FRAMES, default 32, complete 8-digit scans per blink half-period; legal range 1 or more.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 load  input  1  when high, data and blink_mask are captured on that edge.
REQ-006 data  input  32  eight 4-bit digit codes; digit i = data[4i+3:4i], digit 0 rightmost.
REQ-007 blink_mask  input  8  bit i set = digit i blinks.
REQ-008 lz_en  input  1  level, leading-zero suppression enable, not latched.
REQ-009 seg  output  7  segment pattern {a,b,c,d,e,f,g}, active-high.
REQ-010 an  output  8  digit enables, active-low, at most one bit low.
REQ-011 frame  output  1  one-cycle pulse at the end of each full scan.

Function
REQ-012 The block SHALL hold 8 digit registers and a blink-mask register, loaded only by load.
REQ-013 The block SHALL run a cycle counter 0..DIV-1 and assert internal tick when the count equals DIV-1; the counter wraps to 0 on the same edge.
REQ-014 On tick the digit index idx SHALL advance by one, wrapping 7 to 0; otherwise it holds.
REQ-015 Code select: if blink phase is off and blink_mask[idx]=1, select 4'hC (blank).
REQ-016 Code select, otherwise: if lz_en=1, idx>0 and digits idx..7 are all 4'h0, select 4'hC.
REQ-017 Code select, otherwise: select digit[idx].
REQ-018 Digit 0 is never leading-zero suppressed.
REQ-019 The selected code SHALL be decoded with the team encoding: 0-9, A=L, B=C, C=blank, D=P, E=N, F=A.
REQ-020 seg and an SHALL both be registered from the same idx, so each reflects idx one cycle later; an = ~(1<<idx) of that registered idx.
REQ-021 frame SHALL pulse for one cycle on the edge where tick is high and idx=7.
REQ-022 Blink phase SHALL start on (visible).
REQ-023 A frame counter SHALL count frames 0..BLINK_FRAMES-1; at the wrap the blink phase toggles.
REQ-024 If load and tick occur on the same edge, both SHALL take effect, and the new idx uses the new data on the next cycle.
REQ-025 A load never resets idx, the cycle counter or the blink phase.
REQ-026 With DIV=1, idx SHALL advance every cycle with no skipped digit.

Reset
REQ-027 On reset the block SHALL clear digits, blink_mask, idx, cycle counter and frame counter to 0.
REQ-028 On reset the blink phase SHALL be set on, frame=0, an=8'hFF and seg=7'b1111110.
REQ-029 Reset SHALL take priority over load and tick on the same edge.
REQ-030 Reset mid-scan SHALL abandon the current digit; the first post-reset cycle shows an=8'hFE with the decode of 4'h0.

Structure
REQ-031 A shared package SHALL hold the code constants CODE_BLANK=4'hC, CODE_L=4'hA, CODE_C=4'hB, CODE_P=4'hD, CODE_N=4'hE, CODE_A=4'hF, and NDIG=8.
REQ-032 The segment decode SHALL be one sub-module instance, display, with clk, reset and num=selected code; it drives seg.
REQ-033 The an register, counters and selection logic SHALL reside in display_scan.

Verification (DIV=4, BLINK_FRAMES=2 unless noted)
REQ-034 Reset, then load data=32'h76543210, lz_en=0 -> an steps FE,FD,...,7F, every 4 cycles; seg for digit 3 = 7'b1111001; frame pulses once per 32 cycles.
REQ-035 Load data=32'h00000050, lz_en=1 -> digits 7..2 show blank (seg=0), digit 1 shows 7'b1011011, digit 0 shows 7'b1111110.
REQ-036 Load blink_mask=8'h01, data=32'h00000008 -> digit 0 seg alternates 7'b1111111 for 2 frames, then 7'b0000000 for 2 frames; other digits unaffected.
REQ-037 Assert load on the exact tick edge where idx goes 2 to 3 with new digit 3 = 4'hD -> the next cycle shows an=8'hF7 and seg=7'b1100111.
REQ-038 Assert reset while idx=5 mid-digit -> the next cycle shows an=8'hFF and seg=7'b1111110; the cycle after shows an=8'hFE; data reads 0.
REQ-039 DIV=1, data=32'hFEDCBA98 -> an changes every cycle in order; seg shows 8, 9, L, C, blank, P, N, A.
